// File: rtl/mem_port_responder.sv
// Serialises the pipeline's instruction and data memory requests onto one
// backing-memory port, returning both responses together in a single pulse.
module mem_port_responder #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    localparam int unsigned MBE_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_read,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_resp,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_read,
    input  logic              data_write,
    input  logic [MBE_W-1:0]  data_mbe,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_resp,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MBE_W-1:0]  mem_mbe,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    typedef enum logic [1:0] {IDLE, DATA, INST, RESP} state_t;

    state_t            state;
    logic              want_inst;
    logic              inst_done;
    logic              data_done;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] ibuf;
    logic [DATA_W-1:0] dbuf;

    assign inst_rdata = ibuf;
    assign data_rdata = dbuf;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            want_inst <= 1'b0;
            inst_done <= 1'b0;
            data_done <= 1'b0;
            i_addr    <= '0;
            ibuf      <= '0;
            dbuf      <= '0;
            inst_resp <= 1'b0;
            data_resp <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_mbe   <= '0;
        end else begin
            inst_resp <= 1'b0;
            data_resp <= 1'b0;
            case (state)
                IDLE: begin
                    // The resp pulse lands while we are back in IDLE and the
                    // requester still holds its requests; skip that cycle.
                    if (!(inst_resp || data_resp)) begin
                        if (data_read || data_write) begin
                            want_inst <= inst_read;
                            i_addr    <= inst_addr;
                            mem_read  <= !data_write;
                            mem_write <= data_write;
                            mem_addr  <= data_addr;
                            mem_wdata <= data_wdata;
                            mem_mbe   <= data_write ? data_mbe : '1;
                            state     <= DATA;
                        end else if (inst_read) begin
                            i_addr    <= inst_addr;
                            mem_read  <= 1'b1;
                            mem_addr  <= inst_addr;
                            mem_mbe   <= '1;
                            state     <= INST;
                        end
                    end
                end
                DATA: begin
                    if (mem_resp) begin
                        if (!mem_write)
                            dbuf <= mem_rdata;
                        data_done <= 1'b1;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state     <= want_inst ? INST : RESP;
                    end
                end
                INST: begin
                    // Entered from DATA with the port idle: spend one cycle
                    // re-issuing the captured fetch so the beats never merge.
                    if (!mem_read) begin
                        mem_read <= 1'b1;
                        mem_addr <= i_addr;
                        mem_mbe  <= '1;
                    end else if (mem_resp) begin
                        ibuf      <= mem_rdata;
                        inst_done <= 1'b1;
                        mem_read  <= 1'b0;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    inst_resp <= inst_done;
                    data_resp <= data_done;
                    inst_done <= 1'b0;
                    data_done <= 1'b0;
                    want_inst <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_responder.sv
// Directed bench for mem_port_responder: cycle-by-cycle expectations for each
// scenario, with the backing memory driven by hand from the bench.
module tb_mem_port_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_read;
    logic [31:0] inst_addr;
    logic        inst_resp;
    logic [31:0] inst_rdata;
    logic        data_read;
    logic        data_write;
    logic [3:0]  data_mbe;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_resp;
    logic [31:0] data_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mbe;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    int n_total = 0;
    int n_pass  = 0;

    mem_port_responder #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .inst_read(inst_read), .inst_addr(inst_addr),
        .inst_resp(inst_resp), .inst_rdata(inst_rdata),
        .data_read(data_read), .data_write(data_write), .data_mbe(data_mbe),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_resp(data_resp), .data_rdata(data_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_mbe(mem_mbe),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    // Cycle c is the clock period after the c-th posedge following the request;
    // outputs are observed and inputs changed at the negedge inside it.
    task automatic test_reset();
        rst = 1'b1;
        inst_read = 1'b0; inst_addr = '0;
        data_read = 1'b0; data_write = 1'b0; data_mbe = '0;
        data_addr = '0; data_wdata = '0;
        mem_rdata = '0; mem_resp = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({mem_read, mem_write, inst_resp, data_resp} !== 4'b0000)
            $display("FAIL reset_ctrl got=%b exp=0000", {mem_read, mem_write, inst_resp, data_resp});
        else n_pass++;
        n_total++;
        if ({inst_rdata, data_rdata} !== 64'd0)
            $display("FAIL reset_rdata got=%h exp=0", {inst_rdata, data_rdata});
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_data_read();
        logic exp_rd;
        @(negedge clk);
        data_read = 1'b1; data_addr = 32'h100;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            exp_rd = (c >= 1 && c <= 3);
            n_total++;
            if ({mem_read, mem_write} !== {exp_rd, 1'b0})
                $display("FAIL dr_mem_ctrl c=%0d got=%b exp=%b", c, {mem_read, mem_write}, {exp_rd, 1'b0});
            else n_pass++;
            if (c == 1) begin
                n_total++;
                if ({mem_addr, mem_mbe} !== {32'h100, 4'hF})
                    $display("FAIL dr_mem_addr got=%h/%h exp=100/f", mem_addr, mem_mbe);
                else n_pass++;
            end
            n_total++;
            if ({data_resp, inst_resp} !== {(c == 5), 1'b0})
                $display("FAIL dr_resp c=%0d got=%b exp=%b", c, {data_resp, inst_resp}, {(c == 5), 1'b0});
            else n_pass++;
            if (c == 5) begin
                n_total++;
                if (data_rdata !== 32'hDEADBEEF)
                    $display("FAIL dr_rdata got=%h exp=deadbeef", data_rdata);
                else n_pass++;
            end
            mem_resp  = (c == 3);
            mem_rdata = (c == 3) ? 32'hDEADBEEF : 32'h0BAD0BAD;
            if (c == 6) data_read = 1'b0;
        end
    endtask

    task automatic test_inst_and_store();
        @(negedge clk);
        inst_read = 1'b1; inst_addr = 32'h60;
        data_write = 1'b1; data_addr = 32'h200; data_wdata = 32'h12345678; data_mbe = 4'h3;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            case (c)
                1: begin
                    n_total++;
                    if ({mem_write, mem_read, mem_addr, mem_mbe, mem_wdata} !== {2'b10, 32'h200, 4'h3, 32'h12345678})
                        $display("FAIL both_store_beat got=%b%b %h %h %h exp=10 200 3 12345678",
                                 mem_write, mem_read, mem_addr, mem_mbe, mem_wdata);
                    else n_pass++;
                end
                3: begin
                    n_total++;
                    if ({mem_write, mem_read, mem_addr, mem_mbe} !== {2'b01, 32'h60, 4'hF})
                        $display("FAIL both_fetch_beat got=%b%b %h %h exp=01 60 f",
                                 mem_write, mem_read, mem_addr, mem_mbe);
                    else n_pass++;
                end
                default: begin
                    n_total++;
                    if ({mem_write, mem_read} !== 2'b00)
                        $display("FAIL both_mem_idle c=%0d got=%b exp=00", c, {mem_write, mem_read});
                    else n_pass++;
                end
            endcase
            n_total++;
            if ({inst_resp, data_resp} !== {2{c == 5}})
                $display("FAIL both_resp c=%0d got=%b exp=%b", c, {inst_resp, data_resp}, {2{c == 5}});
            else n_pass++;
            if (c == 5) begin
                n_total++;
                if ({inst_rdata, data_rdata} !== {32'hA5A50001, 32'hDEADBEEF})
                    $display("FAIL both_rdata got=%h/%h exp=a5a50001/deadbeef", inst_rdata, data_rdata);
                else n_pass++;
            end
            mem_resp  = (c == 1 || c == 3);
            mem_rdata = (c == 3) ? 32'hA5A50001 : 32'hFFFFFFFF;
            if (c == 6) begin inst_read = 1'b0; data_write = 1'b0; end
        end
    endtask

    task automatic test_inst_only();
        @(negedge clk);
        inst_read = 1'b1; inst_addr = 32'h40;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            n_total++;
            if ({mem_read, mem_write} !== {(c == 1), 1'b0})
                $display("FAIL io_mem_ctrl c=%0d got=%b exp=%b", c, {mem_read, mem_write}, {(c == 1), 1'b0});
            else n_pass++;
            if (c == 1) begin
                n_total++;
                if (mem_addr !== 32'h40)
                    $display("FAIL io_mem_addr got=%h exp=40", mem_addr);
                else n_pass++;
            end
            n_total++;
            if ({inst_resp, data_resp} !== {(c == 3), 1'b0})
                $display("FAIL io_resp c=%0d got=%b exp=%b", c, {inst_resp, data_resp}, {(c == 3), 1'b0});
            else n_pass++;
            if (c >= 3) begin
                n_total++;
                if (inst_rdata !== 32'h00000013)
                    $display("FAIL io_rdata c=%0d got=%h exp=00000013", c, inst_rdata);
                else n_pass++;
            end
            mem_resp  = (c == 1);
            mem_rdata = (c == 1) ? 32'h00000013 : 32'h77777777;
            if (c == 4) inst_read = 1'b0;
        end
    endtask

    task automatic test_dropped_request();
        @(negedge clk);
        data_read = 1'b1; data_addr = 32'h500;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) data_read = 1'b0;
            n_total++;
            if (mem_read !== (c <= 2))
                $display("FAIL drop_mem_read c=%0d got=%b exp=%b", c, mem_read, (c <= 2));
            else n_pass++;
            n_total++;
            if (data_resp !== (c == 4))
                $display("FAIL drop_resp c=%0d got=%b exp=%b", c, data_resp, (c == 4));
            else n_pass++;
            if (c == 4) begin
                n_total++;
                if (data_rdata !== 32'h5555AAAA)
                    $display("FAIL drop_rdata got=%h exp=5555aaaa", data_rdata);
                else n_pass++;
            end
            mem_resp  = (c == 2);
            mem_rdata = (c == 2) ? 32'h5555AAAA : 32'h0;
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        data_read = 1'b1; data_addr = 32'h300;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            n_total++;
            if ({mem_read, mem_write} !== {(c <= 2), 1'b0})
                $display("FAIL rst_mem_ctrl c=%0d got=%b exp=%b", c, {mem_read, mem_write}, {(c <= 2), 1'b0});
            else n_pass++;
            n_total++;
            if ({inst_resp, data_resp} !== 2'b00)
                $display("FAIL rst_resp c=%0d got=%b exp=00", c, {inst_resp, data_resp});
            else n_pass++;
            if (c == 3) begin
                n_total++;
                if ({inst_rdata, data_rdata} !== 64'd0)
                    $display("FAIL rst_bufs got=%h/%h exp=0/0", inst_rdata, data_rdata);
                else n_pass++;
            end
            rst = (c == 2);
            if (c == 3) data_read = 1'b0;
            mem_resp  = (c == 4);
            mem_rdata = 32'h1234ABCD;
        end
    endtask

    task automatic test_idle_mem_resp();
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            n_total++;
            if ({mem_read, mem_write, inst_resp, data_resp} !== 4'b0000)
                $display("FAIL idle_ctrl c=%0d got=%b exp=0000", c, {mem_read, mem_write, inst_resp, data_resp});
            else n_pass++;
            mem_resp  = (c <= 2);
            mem_rdata = 32'hBEEFCAFE;
        end
        n_total++;
        if ({inst_rdata, data_rdata} !== 64'd0)
            $display("FAIL idle_bufs got=%h/%h exp=0/0", inst_rdata, data_rdata);
        else n_pass++;
    endtask

    task automatic test_read_write_both();
        int pulses = 0;
        @(negedge clk);
        data_read = 1'b1; data_write = 1'b1;
        data_addr = 32'h400; data_wdata = 32'hCAFEF00D; data_mbe = 4'hC;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (data_resp) pulses++;
            n_total++;
            if (mem_read !== 1'b0)
                $display("FAIL rw_no_read c=%0d got=%b exp=0", c, mem_read);
            else n_pass++;
            n_total++;
            if (mem_write !== (c <= 2))
                $display("FAIL rw_write c=%0d got=%b exp=%b", c, mem_write, (c <= 2));
            else n_pass++;
            if (c == 1) begin
                n_total++;
                if ({mem_addr, mem_wdata, mem_mbe} !== {32'h400, 32'hCAFEF00D, 4'hC})
                    $display("FAIL rw_fields got=%h %h %h exp=400 cafef00d c", mem_addr, mem_wdata, mem_mbe);
                else n_pass++;
            end
            mem_resp  = (c == 2);
            mem_rdata = 32'h99999999;
            if (c == 5) begin data_read = 1'b0; data_write = 1'b0; end
        end
        n_total++;
        if (pulses != 1)
            $display("FAIL rw_resp_count got=%0d exp=1", pulses);
        else n_pass++;
        n_total++;
        if (data_rdata !== 32'd0)
            $display("FAIL rw_rdata_untouched got=%h exp=0", data_rdata);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_data_read();
        test_inst_and_store();
        test_inst_only();
        test_dropped_request();
        test_mid_reset();
        test_idle_mem_resp();
        test_read_write_both();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
